// File: rtl/sr_transmit_ctrl_if.sv
// Serial valid/ready link between the transmit sequencer and its sink.
// The sequencer side uses the master modport.
interface sr_transmit_ctrl_if;
  logic ser_out;
  logic ser_valid;
  logic ser_ready;

  modport master (
    output ser_out,
    output ser_valid,
    input  ser_ready
  );

  modport slave (
    input  ser_out,
    input  ser_valid,
    output ser_ready
  );
endinterface

// File: rtl/sr_transmit_ctrl.sv
// Row-by-row transmit sequencer for a flattened ROWS x D matrix.
// Define SR_TX_SCRAMBLE_EN to whiten the serial stream with a 16-bit LFSR.
module sr_transmit_ctrl #(
  parameter  int D    = 8,
  parameter  int ROWS = 4,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int BW   = (D > 1) ? $clog2(D) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [D*ROWS-1:0]   mat_in,
  output logic                busy,
  output logic                ld,
  output logic [D-1:0]        row_out,
  output logic                done,
  sr_transmit_ctrl_if.master  ser
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                  state;
  logic [ROWS-1:0][D-1:0]  mat_q;
  logic [D-1:0]            shift_q;
  logic [D-1:0]            shift_nx;
  logic [D-1:0]            row_nx;
  logic [RW-1:0]           row_idx;
  logic [RW-1:0]           row_inc;
  logic [BW-1:0]           bit_cnt;
  logic                    last_row;
  logic                    ser_out_q;
  logic                    ser_valid_q;
  logic                    scr_cur;
  logic                    scr_nx;

  assign shift_nx      = shift_q << 1;
  assign row_inc       = row_idx + 1'b1;
  assign row_nx        = mat_q[row_inc];
  assign last_row      = (row_idx == RW'(ROWS - 1));
  assign ser.ser_out   = ser_out_q;
  assign ser.ser_valid = ser_valid_q;

`ifdef SR_TX_SCRAMBLE_EN
  localparam logic [15:0] SEED = 16'hACE1;

  logic [15:0] lfsr;
  logic [15:0] lfsr_nx;

  assign lfsr_nx = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
                    lfsr[15:1]};
  assign scr_cur = lfsr[0];
  assign scr_nx  = lfsr_nx[0];

  // Advances only on accepted bits so stalls never skip a mask bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (state == IDLE && start) begin
      lfsr <= SEED;
    end else if (state == SHIFT && ser.ser_ready) begin
      lfsr <= lfsr_nx;
    end
  end
`else
  assign scr_cur = 1'b0;
  assign scr_nx  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mat_q       <= '0;
      shift_q     <= '0;
      row_idx     <= '0;
      bit_cnt     <= '0;
      busy        <= 1'b0;
      ld          <= 1'b0;
      row_out     <= '0;
      done        <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mat_q   <= mat_in;
            row_idx <= '0;
            row_out <= mat_in[D-1:0];
            ld      <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          ld          <= 1'b0;
          shift_q     <= row_out;
          bit_cnt     <= BW'(D - 1);
          ser_valid_q <= 1'b1;
          ser_out_q   <= row_out[D-1] ^ scr_cur;
          state       <= SHIFT;
        end
        SHIFT: begin
          if (ser.ser_ready) begin
            shift_q <= shift_nx;
            if (bit_cnt == '0) begin
              ser_valid_q <= 1'b0;
              ser_out_q   <= 1'b0;
              if (last_row) begin
                row_out <= '0;
                done    <= 1'b1;
                state   <= DONE;
              end else begin
                row_idx <= row_inc;
                row_out <= row_nx;
                ld      <= 1'b1;
                state   <= LOAD;
              end
            end else begin
              bit_cnt   <= bit_cnt - 1'b1;
              ser_out_q <= shift_nx[D-1] ^ scr_nx;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_transmit_ctrl.sv
// Bench for sr_transmit_ctrl: cycle table, directed corners, random scoreboard.
// Expected serial bits come from the matrix and an LFSR model when scrambled.
module tb_sr_transmit_ctrl;
  localparam int D     = 8;
  localparam int ROWS  = 4;
  localparam int W     = D * ROWS;
  localparam int LIMIT = 600;
  localparam int NLOG  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] mat_in;
  logic         busy;
  logic         ld;
  logic [D-1:0] row_out;
  logic         done;

  sr_transmit_ctrl_if sif ();

  sr_transmit_ctrl #(
    .D    (D),
    .ROWS (ROWS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mat_in  (mat_in),
    .busy    (busy),
    .ld      (ld),
    .row_out (row_out),
    .done    (done),
    .ser     (sif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int last_done_cyc;

  logic         log_ld    [NLOG];
  logic         log_valid [NLOG];
  logic         log_out   [NLOG];
  logic         log_done  [NLOG];
  logic         log_busy  [NLOG];
  logic [D-1:0] log_row   [NLOG];

  typedef struct {
    int           cyc;
    logic         ld;
    logic [D-1:0] row;
    logic         valid;
    logic         sout;
    int           k;
    logic         done;
    logic         busy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic lfsr_bit(input int k);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < k; i++)
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return s[0];
  endfunction

  function automatic logic scr(input int k);
`ifdef SR_TX_SCRAMBLE_EN
    return lfsr_bit(k);
`else
    return (k < 0) ? 1'b1 : 1'b0;
`endif
  endfunction

  function automatic logic [D-1:0] row_of(input logic [W-1:0] m,
                                          input int r);
    return m[r*D +: D];
  endfunction

  // k-th accepted bit of a whole transfer: rows in order, MSB first.
  function automatic logic model_bit(input logic [W-1:0] m, input int k);
    logic [D-1:0] r;
    r = row_of(m, k / D);
    return r[D-1-(k % D)] ^ scr(k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input logic [W-1:0] m, input int pct,
                          input int stall_at, input int stall_len,
                          input int noise_cyc, input int noise_pct);
    int   acc;
    int   stalls;
    int   stl;
    int   t;
    bit   pend_ld;
    bit   pend_done;
    bit   fin;
    bit   e_ld;
    bit   e_done;
    bit   e_valid;
    bit   rdy;
    bit   took;
    logic [D-1:0] e_row;
    acc = 0; stalls = 0; stl = 0; t = 0;
    pend_ld = 1'b1; pend_done = 1'b0; fin = 1'b0;
    mat_in = m;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    while (!fin) begin
      t++;
      if (t > LIMIT) begin
        checks++;
        errors++;
        $display("FAIL timeout: no done after %0d cycles", LIMIT);
        break;
      end
      rdy = ($urandom_range(99) < pct);
      if (acc == stall_at && stl < stall_len) rdy = 1'b0;
      sif.ser_ready = rdy;
      if (t == noise_cyc || $urandom_range(99) < noise_pct) begin
        start  = 1'b1;
        mat_in = (t == noise_cyc) ? '1 : W'({$urandom, $urandom});
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      e_ld    = pend_ld;
      e_done  = pend_done;
      e_valid = !e_ld && !e_done;
      e_row   = e_done ? '0 : row_of(m, acc / D);
      chk($sformatf("c%0d_ld", t), ld, e_ld);
      chk($sformatf("c%0d_done", t), done, e_done);
      chk($sformatf("c%0d_valid", t), sif.ser_valid, e_valid);
      chk($sformatf("c%0d_busy", t), busy, 1'b1);
      chk($sformatf("c%0d_row", t), row_out, e_row);
      if (e_valid)
        chk($sformatf("c%0d_bit%0d", t, acc), sif.ser_out,
            model_bit(m, acc));
      if (t < NLOG) begin
        log_ld[t]    = ld;
        log_valid[t] = sif.ser_valid;
        log_out[t]   = sif.ser_out;
        log_done[t]  = done;
        log_busy[t]  = busy;
        log_row[t]   = row_out;
      end
      took = e_valid && rdy;
      if (e_valid && !rdy) begin
        stalls++;
        if (acc == stall_at) stl++;
      end
      if (took) acc++;
      pend_ld   = took && (acc % D == 0) && (acc < ROWS * D);
      pend_done = took && (acc == ROWS * D);
      if (e_done) begin
        chk("done_cycle", t, ROWS * (D + 1) + 1 + stalls);
        last_done_cyc = t;
        fin = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    sif.ser_ready = 1'($urandom_range(1));
    @(negedge clk);
    t++;
    chk("idle_busy", busy, 1'b0);
    chk("idle_ld", ld, 1'b0);
    chk("idle_valid", sif.ser_valid, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_row", row_out, '0);
    if (t < NLOG) begin
      log_ld[t]    = ld;
      log_valid[t] = sif.ser_valid;
      log_out[t]   = sif.ser_out;
      log_done[t]  = done;
      log_busy[t]  = busy;
      log_row[t]   = row_out;
    end
    tick();
  endtask

  initial begin
    //        cyc ld row    vld sout k   done busy
    tbl[0]  = '{1,  1, 8'h81, 0, 0,  -1, 0, 1};
    tbl[1]  = '{2,  0, 8'h81, 1, 1,  0,  0, 1};
    tbl[2]  = '{3,  0, 8'h81, 1, 0,  1,  0, 1};
    tbl[3]  = '{9,  0, 8'h81, 1, 1,  7,  0, 1};
    tbl[4]  = '{10, 1, 8'h0F, 0, 0,  -1, 0, 1};
    tbl[5]  = '{11, 0, 8'h0F, 1, 0,  8,  0, 1};
    tbl[6]  = '{15, 0, 8'h0F, 1, 1,  12, 0, 1};
    tbl[7]  = '{19, 1, 8'h3C, 0, 0,  -1, 0, 1};
    tbl[8]  = '{28, 1, 8'hA5, 0, 0,  -1, 0, 1};
    tbl[9]  = '{29, 0, 8'hA5, 1, 1,  24, 0, 1};
    tbl[10] = '{36, 0, 8'hA5, 1, 1,  31, 0, 1};
    tbl[11] = '{37, 0, 8'h00, 0, 0,  -1, 1, 1};
    tbl[12] = '{38, 0, 8'h00, 0, 0,  -1, 0, 0};

    rst = 1'b1;
    start = 1'b1;
    mat_in = 32'hA53C0F81;
    sif.ser_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_ld", ld, 1'b0);
      chk("rst_valid", sif.ser_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_row", row_out, '0);
      chk("rst_sout", sif.ser_out, 1'b0);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ld", ld, 1'b0);

    run_xfer(32'hA53C0F81, 100, -1, 0, -1, 0);
    chk("basic_done_cycle", last_done_cyc, 37);
    for (int i = 0; i < 13; i++) begin
      int c;
      c = tbl[i].cyc;
      chk($sformatf("tbl_c%0d_ld", c), log_ld[c], tbl[i].ld);
      chk($sformatf("tbl_c%0d_row", c), log_row[c], tbl[i].row);
      chk($sformatf("tbl_c%0d_valid", c), log_valid[c], tbl[i].valid);
      chk($sformatf("tbl_c%0d_done", c), log_done[c], tbl[i].done);
      chk($sformatf("tbl_c%0d_busy", c), log_busy[c], tbl[i].busy);
      if (tbl[i].valid)
        chk($sformatf("tbl_c%0d_sout", c), log_out[c],
            tbl[i].sout ^ scr(tbl[i].k));
    end

    // Five-cycle stall on bit 3 of row 1 pushes done by five cycles.
    run_xfer(32'hA53C0F81, 100, D + 3, 5, -1, 0);
    chk("bp_done_cycle", last_done_cyc, 42);

    // A second start with all-ones data during the transfer is ignored.
    run_xfer(32'hA53C0F81, 100, -1, 0, 5, 0);
    chk("iso_done_cycle", last_done_cyc, 37);

    mat_in = 32'hA53C0F81;
    start = 1'b1;
    sif.ser_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("mid_busy_c15", busy, 1'b1);
    chk("mid_valid_c15", sif.ser_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ld", ld, 1'b0);
    chk("abort_valid", sif.ser_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_row", row_out, '0);
    chk("abort_sout", sif.ser_out, 1'b0);
    tick();
    chk("abort_no_done", done, 1'b0);
    chk("abort_idle", busy, 1'b0);
    run_xfer(32'h000000FF, 100, -1, 0, -1, 0);
    chk("ff_row_c1", log_row[1], 8'hFF);

    run_xfer('0, 100, -1, 0, -1, 0);
`ifdef SR_TX_SCRAMBLE_EN
    chk("scr_bit0", log_out[2], 1'b1);
    chk("scr_bit1", log_out[3], 1'b0);
    chk("scr_bit2", log_out[4], 1'b0);
`endif
    run_xfer('0, 50, -1, 0, -1, 0);

    for (int n = 0; n < 8; n++)
      run_xfer(W'({$urandom, $urandom}), 60, -1, 0, -1, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_transmit_ctrl.md
Name: sr_transmit_ctrl

Overview:
- Transmit sequencer for the 2D-flattening path.
- Captures a flattened ROWS x D matrix on a start pulse.
- Loads each row in turn into the transmit shift register: one ld strobe plus row_out per row.
- Serializes each row MSB-first over a valid/ready serial interface and pulses done after the last bit.

Parameters:
D, 8, row width in bits (transmit register width)
ROWS, 4, number of rows in the flattened matrix
RW, $clog2(ROWS) (min 1), row index width (derived, not overridden)
BW, $clog2(D) (min 1), bit counter width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request; sampled only in IDLE
mat_in  in  D*ROWS  flattened matrix; row r = mat_in[r*D +: D]
busy  out  1  high in every state except IDLE
ld  out  1  one-cycle load strobe to transmit register
row_out  out  D  row currently being loaded/sent
ser_out  out  1  serial data bit
ser_valid  out  1  ser_out is valid
ser_ready  in  1  sink accepts bit when ser_valid && ser_ready
done  out  1  one-cycle pulse after last bit accepted

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE.
  - mat_q, shift_q, row_idx and bit_cnt cleared.
  - All outputs 0.
  - Reset dominates every other input. Asserting it mid-operation aborts the transfer and gives no done pulse.
- Registered FSM with states IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 → mat_q<=mat_in, row_idx<=0, go to LOAD.
  - start while not IDLE is ignored.
  - mat_in changes after capture have no effect.
- LOAD (exactly 1 cycle):
  - ld=1, row_out=mat_q row[row_idx].
  - shift_q<=that row, bit_cnt<=D-1, go to SHIFT.
- SHIFT:
  - ser_valid=1, ser_out=shift_q[D-1].
  - On ser_ready=1 (bit accepted):
    - shift_q<=shift_q<<1.
    - If bit_cnt==0: go to DONE if row_idx==ROWS-1, else row_idx+1 and go to LOAD.
    - Otherwise bit_cnt-1.
  - ser_ready=0 stalls: ser_out, ser_valid, row_out, bit_cnt and row_idx all hold. No bit is lost or duplicated.
- DONE (1 cycle): done=1, busy=1, then go to IDLE. A start in this cycle is ignored.
- row_out holds the last loaded row through SHIFT. It is 0 in IDLE and DONE.
- Timing with ser_ready held at 1 and start sampled at edge 0:
  - Row r: LOAD in cycle 1+r*(D+1), SHIFT in cycles 2+r*(D+1) .. (r+1)*(D+1).
  - DONE in cycle ROWS*(D+1)+1.
  - Each stall cycle adds 1.
- No combinational path from ser_ready to ser_out or ser_valid (both are decoded from registered state).

Optional Feature:
SR_TX_SCRAMBLE_EN
- Defined:
  - 16-bit LFSR, seeded 16'hACE1 on the start capture.
  - Fibonacci, shifts right, feedback into bit 15 = b0^b2^b3^b5.
  - ser_out = shift_q[D-1] ^ lfsr[0].
  - LFSR advances only on accepted bits. It holds on stalls and in LOAD.
  - Reset clears the LFSR to the seed.
  - row_out and ld are unaffected.
- Not defined: no LFSR logic; ser_out = shift_q[D-1].

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 → busy, ld, ser_valid, done, row_out, ser_out all 0; FSM stays IDLE.
- Basic (D=8, ROWS=4): mat_in=32'hA53C0F81, start pulse, ser_ready=1 →
  - cycle 1: ld=1, row_out=8'h81; cycles 2-9: ser_out 1,0,0,0,0,0,0,1.
  - cycle 10: row_out=8'h0F; cycle 28: row_out=8'hA5.
  - done=1 in cycle 37 only; busy=0 from cycle 38.
- Backpressure: ser_ready=0 for 5 cycles while sending bit 3 of row 1 (8'h0F) → ser_out=0 and ser_valid=1 held; accepted stream still 0,0,0,0,1,1,1,1; done moves to cycle 42.
- Start/data isolation: second start and mat_in=32'hFFFFFFFF applied in cycle 5 → ignored; stream still matches 32'hA53C0F81; exactly one done.
- Reset mid-shift: rst=1 in cycle 15 → cycle 16 all outputs 0, no done; new start with mat_in=32'h000000FF → ld with row_out=8'hFF, then eight 1s, then 24 zeros.
- Scramble (SR_TX_SCRAMBLE_EN, mat_in=0): start, ser_ready=1 → first three accepted ser_out bits 1,0,0, following the LFSR bit-0 sequence from 16'hACE1; with ser_ready toggling the sequence is unchanged.
